// File: rtl/i2c_codec_responder.sv
// rtl/i2c_codec_responder.sv - I2C write-only codec register target (reads when I2C_RESPONDER_READBACK_EN is defined)
module i2c_codec_responder #(
   parameter logic [6:0] DEV_ADDR    = 7'h1A,
   parameter int         SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       scl_in,
   input  logic       sda_in,
   output logic       sda_oe,
   output logic       wr_valid,
   output logic [6:0] wr_addr,
   output logic [8:0] wr_data,
   input  logic [3:0] reg_sel,
   output logic [8:0] reg_q,
   output logic       busy
);

   localparam logic [3:0] S_IDLE     = 4'd0;
   localparam logic [3:0] S_ADDR     = 4'd1;
   localparam logic [3:0] S_ADDR_ACK = 4'd2;
   localparam logic [3:0] S_BYTE1    = 4'd3;
   localparam logic [3:0] S_ACK1     = 4'd4;
   localparam logic [3:0] S_BYTE2    = 4'd5;
   localparam logic [3:0] S_ACK2     = 4'd6;
   localparam logic [3:0] S_IGNORE   = 4'd7;
`ifdef I2C_RESPONDER_READBACK_EN
   localparam logic [3:0] S_RD_BYTE  = 4'd8;
   localparam logic [3:0] S_RD_ACK   = 4'd9;
`endif

   localparam logic [6:0] CLEAR_ADDR = 7'h0F;
   localparam logic [6:0] LAST_REG   = 7'd9;

   logic [SYNC_STAGES-1:0] r_scl_sync;
   logic [SYNC_STAGES-1:0] r_sda_sync;
   logic                   r_scl_d;
   logic                   r_sda_d;

   logic       w_scl;
   logic       w_sda;
   logic       w_start;
   logic       w_stop;
   logic       w_scl_rise;
   logic       w_scl_fall;

   logic [3:0] r_state;
   logic [3:0] r_bit_cnt;
   logic [7:0] r_shift;
   logic [6:0] r_reg_addr;
   logic       r_data_hi;
   logic       r_sda_oe;
   logic       r_wr_valid;
   logic [6:0] r_wr_addr;
   logic [8:0] r_wr_data;
   logic [8:0] r_reg_q;
   logic [8:0] r_regs [0:9];

`ifdef I2C_RESPONDER_READBACK_EN
   logic       r_rd;
   logic       r_rd_second;
   logic       r_rd_nack;
   logic [7:0] r_tx;
   logic [8:0] w_rd_word;

   // Read data always comes from the most recently written register
   assign w_rd_word = (r_wr_addr <= LAST_REG) ? r_regs[r_wr_addr[3:0]] : 9'd0;
`endif

   // Two-or-more flop synchronisers; idle bus is high
   always_ff @(posedge clk) begin
      if (reset) begin
         r_scl_sync <= '1;
         r_sda_sync <= '1;
      end else begin
         r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_in};
         r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_in};
      end
   end

   // Previous synchronised values for edge and START/STOP detection
   always_ff @(posedge clk) begin
      if (reset) begin
         r_scl_d <= 1'b1;
         r_sda_d <= 1'b1;
      end else begin
         r_scl_d <= w_scl;
         r_sda_d <= w_sda;
      end
   end

   assign w_scl      = r_scl_sync[SYNC_STAGES-1];
   assign w_sda      = r_sda_sync[SYNC_STAGES-1];
   assign w_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
   assign w_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;
   assign w_scl_rise = w_scl & ~r_scl_d;
   assign w_scl_fall = ~w_scl & r_scl_d;

   // Protocol FSM: bit shifting on SCL rise, SDA drive and state moves on SCL fall, write commit
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_bit_cnt  <= 4'd0;
         r_shift    <= 8'd0;
         r_reg_addr <= 7'd0;
         r_data_hi  <= 1'b0;
         r_sda_oe   <= 1'b0;
         r_wr_valid <= 1'b0;
         r_wr_addr  <= 7'd0;
         r_wr_data  <= 9'd0;
         for (int i = 0; i < 10; i++) r_regs[i] <= 9'd0;
`ifdef I2C_RESPONDER_READBACK_EN
         r_rd        <= 1'b0;
         r_rd_second <= 1'b0;
         r_rd_nack   <= 1'b0;
         r_tx        <= 8'd0;
`endif
      end else begin
         r_wr_valid <= 1'b0;
         // STOP outranks everything so a partial byte pair is always dropped
         if (w_stop) begin
            r_state   <= S_IDLE;
            r_sda_oe  <= 1'b0;
            r_bit_cnt <= 4'd0;
         end else if (w_start) begin
            r_state   <= S_ADDR;
            r_sda_oe  <= 1'b0;
            r_bit_cnt <= 4'd0;
         end else if (w_scl_rise) begin
            if (r_state == S_ADDR || r_state == S_BYTE1 || r_state == S_BYTE2) begin
               r_shift   <= {r_shift[6:0], w_sda};
               r_bit_cnt <= r_bit_cnt + 4'd1;
            end
`ifdef I2C_RESPONDER_READBACK_EN
            if (r_state == S_RD_ACK) r_rd_nack <= w_sda;
`endif
         end else if (w_scl_fall) begin
            case (r_state)
               S_ADDR: begin
                  // The first fall right after START arrives with a zero count and is skipped
                  if (r_bit_cnt == 4'd8) begin
                     r_bit_cnt <= 4'd0;
                     if (r_shift[7:1] == DEV_ADDR && !r_shift[0]) begin
                        r_state  <= S_ADDR_ACK;
                        r_sda_oe <= 1'b1;
`ifdef I2C_RESPONDER_READBACK_EN
                        r_rd     <= 1'b0;
                     end else if (r_shift[7:1] == DEV_ADDR) begin
                        r_state  <= S_ADDR_ACK;
                        r_sda_oe <= 1'b1;
                        r_rd     <= 1'b1;
`endif
                     end else begin
                        r_state  <= S_IGNORE;
                        r_sda_oe <= 1'b0;
                     end
                  end
               end
               S_ADDR_ACK: begin
                  r_bit_cnt <= 4'd0;
`ifdef I2C_RESPONDER_READBACK_EN
                  if (r_rd) begin
                     // First read byte carries only the ninth data bit
                     r_state     <= S_RD_BYTE;
                     r_rd_second <= 1'b0;
                     r_tx        <= {7'd0, w_rd_word[8]};
                     r_sda_oe    <= 1'b1;
                  end else begin
                     r_state  <= S_BYTE1;
                     r_sda_oe <= 1'b0;
                  end
`else
                  r_state  <= S_BYTE1;
                  r_sda_oe <= 1'b0;
`endif
               end
               S_BYTE1: begin
                  if (r_bit_cnt == 4'd8) begin
                     r_bit_cnt  <= 4'd0;
                     r_reg_addr <= r_shift[7:1];
                     r_data_hi  <= r_shift[0];
                     r_state    <= S_ACK1;
                     r_sda_oe   <= 1'b1;
                  end
               end
               S_ACK1: begin
                  r_state   <= S_BYTE2;
                  r_sda_oe  <= 1'b0;
                  r_bit_cnt <= 4'd0;
               end
               S_BYTE2: begin
                  if (r_bit_cnt == 4'd8) begin
                     r_bit_cnt <= 4'd0;
                     r_state   <= S_ACK2;
                     r_sda_oe  <= 1'b1;
                     // Commit on entry to ACK2; unknown registers are ACKed but dropped
                     if (r_reg_addr <= LAST_REG) begin
                        r_regs[r_reg_addr[3:0]] <= {r_data_hi, r_shift};
                        r_wr_valid <= 1'b1;
                        r_wr_addr  <= r_reg_addr;
                        r_wr_data  <= {r_data_hi, r_shift};
                     end else if (r_reg_addr == CLEAR_ADDR) begin
                        for (int i = 0; i < 10; i++) r_regs[i] <= 9'd0;
                        r_wr_valid <= 1'b1;
                        r_wr_addr  <= r_reg_addr;
                        r_wr_data  <= {r_data_hi, r_shift};
                     end
                  end
               end
               S_ACK2: begin
                  r_state   <= S_BYTE1;
                  r_sda_oe  <= 1'b0;
                  r_bit_cnt <= 4'd0;
               end
`ifdef I2C_RESPONDER_READBACK_EN
               S_RD_BYTE: begin
                  if (r_bit_cnt == 4'd7) begin
                     r_bit_cnt <= 4'd0;
                     r_state   <= S_RD_ACK;
                     r_sda_oe  <= 1'b0;
                  end else begin
                     r_bit_cnt <= r_bit_cnt + 4'd1;
                     r_sda_oe  <= ~r_tx[6];
                     r_tx      <= {r_tx[6:0], 1'b0};
                  end
               end
               S_RD_ACK: begin
                  r_bit_cnt <= 4'd0;
                  if (r_rd_nack) begin
                     r_state  <= S_IDLE;
                     r_sda_oe <= 1'b0;
                  end else if (!r_rd_second) begin
                     r_state     <= S_RD_BYTE;
                     r_rd_second <= 1'b1;
                     r_tx        <= w_rd_word[7:0];
                     r_sda_oe    <= ~w_rd_word[7];
                  end else begin
                     r_state     <= S_RD_BYTE;
                     r_rd_second <= 1'b0;
                     r_tx        <= {7'd0, w_rd_word[8]};
                     r_sda_oe    <= ~w_rd_word[8];
                  end
               end
`endif
               default: begin
                  r_sda_oe <= 1'b0;
               end
            endcase
         end
      end
   end

   // Registered register-file readout; unpopulated selects return zero
   always_ff @(posedge clk) begin
      if (reset) begin
         r_reg_q <= 9'd0;
      end else begin
         r_reg_q <= (reg_sel <= 4'd9) ? r_regs[reg_sel] : 9'd0;
      end
   end

   assign sda_oe   = r_sda_oe;
   assign wr_valid = r_wr_valid;
   assign wr_addr  = r_wr_addr;
   assign wr_data  = r_wr_data;
   assign reg_q    = r_reg_q;
   assign busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_i2c_codec_responder.sv
// tb/tb_i2c_codec_responder.sv - directed bench for i2c_codec_responder
module tb_i2c_codec_responder;

   localparam int Q = 8;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       scl_m = 1'b1;
   logic       sda_m = 1'b1;
   logic [3:0] reg_sel = 4'd0;
   logic       sda_line;
   logic       sda_oe;
   logic       wr_valid;
   logic [6:0] wr_addr;
   logic [8:0] wr_data;
   logic [8:0] reg_q;
   logic       busy;

   int n_checks = 0;
   int n_fail = 0;
   int wr_pulses = 0;
   int oe_clks = 0;

   assign sda_line = sda_m & ~sda_oe;

   i2c_codec_responder #(.DEV_ADDR(7'h1A), .SYNC_STAGES(2)) dut (
      .clk      (clk),
      .reset    (reset),
      .scl_in   (scl_m),
      .sda_in   (sda_line),
      .sda_oe   (sda_oe),
      .wr_valid (wr_valid),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .reg_sel  (reg_sel),
      .reg_q    (reg_q),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (wr_valid) wr_pulses <= wr_pulses + 1;
      if (sda_oe) oe_clks <= oe_clks + 1;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic i2c_start();
      sda_m = 1'b1; tick(Q);
      scl_m = 1'b1; tick(Q);
      sda_m = 1'b0; tick(Q);
      scl_m = 1'b0; tick(Q);
   endtask

   task automatic i2c_stop();
      sda_m = 1'b0; tick(Q);
      scl_m = 1'b1; tick(Q);
      sda_m = 1'b1; tick(Q);
   endtask

   task automatic send_bit(input logic b);
      sda_m = b;    tick(Q);
      scl_m = 1'b1; tick(Q);
      scl_m = 1'b0; tick(Q);
   endtask

   task automatic send_bits(input logic [7:0] b, input int n);
      for (int i = 7; i > 7 - n; i--) send_bit(b[i]);
   endtask

   task automatic send_byte(input logic [7:0] b, output logic ack);
      send_bits(b, 8);
      sda_m = 1'b1; tick(Q);
      scl_m = 1'b1; tick(Q / 2);
      ack = ~sda_line;
      tick(Q / 2);
      scl_m = 1'b0; tick(Q);
   endtask

   task automatic read_byte(output logic [7:0] d);
      for (int i = 7; i >= 0; i--) begin
         sda_m = 1'b1; tick(Q);
         scl_m = 1'b1; tick(Q / 2);
         d[i] = sda_line;
         tick(Q / 2);
         scl_m = 1'b0; tick(Q);
      end
   endtask

   task automatic write3(input logic [7:0] a, input logic [7:0] b1, input logic [7:0] b2,
                         output logic [2:0] acks);
      i2c_start();
      send_byte(a, acks[2]);
      send_byte(b1, acks[1]);
      send_byte(b2, acks[0]);
      i2c_stop();
   endtask

   task automatic read_reg(input logic [3:0] sel, output logic [8:0] q);
      reg_sel = sel;
      tick(2);
      q = reg_q;
   endtask

   initial begin
      logic [2:0] acks;
      logic       ack;
      logic [8:0] q;
      logic [7:0] d;
      int         w0;
      int         o0;

      // Reset state
      tick(4);
      check("rst_sda_oe", sda_oe, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_wr_valid", wr_valid, 1'b0);
      check("rst_wr_addr", wr_addr, 7'd0);
      check("rst_wr_data", wr_data, 9'd0);
      check("rst_reg_q", reg_q, 9'd0);
      reset = 1'b0;
      tick(Q);

      // Basic write: reg 4 = 0x012
      w0 = wr_pulses;
      i2c_start();
      check("wr_busy_after_start", busy, 1'b1);
      send_byte(8'h34, acks[2]);
      send_byte(8'h08, acks[1]);
      send_byte(8'h12, acks[0]);
      i2c_stop();
      check("wr_acks", acks, 3'b111);
      check("wr_busy_after_stop", busy, 1'b0);
      check("wr_pulses", wr_pulses - w0, 1);
      check("wr_addr", wr_addr, 7'd4);
      check("wr_data", wr_data, 9'h012);
      read_reg(4'd4, q);
      check("reg4_q", q, 9'h012);

      // Wrong address 0x1B: never ACKed, ignored until STOP
      w0 = wr_pulses;
      o0 = oe_clks;
      i2c_start();
      send_byte(8'h36, ack);
      send_byte(8'h08, acks[1]);
      check("bad_addr_ack", ack, 1'b0);
      check("bad_addr_busy", busy, 1'b1);
      i2c_stop();
      check("bad_addr_oe_clks", oe_clks - o0, 0);
      check("bad_addr_busy_stop", busy, 1'b0);
      check("bad_addr_pulses", wr_pulses - w0, 0);

      // Register above 9 and not 0x0F: ACKed, discarded
      w0 = wr_pulses;
      write3(8'h34, 8'h18, 8'h44, acks);
      check("reg12_acks", acks, 3'b111);
      check("reg12_pulses", wr_pulses - w0, 0);
      check("reg12_wr_addr_held", wr_addr, 7'd4);

      // Writes to 2 and 5, then clear-all via 0x0F
      write3(8'h34, 8'h04, 8'hAA, acks);
      write3(8'h34, 8'h0B, 8'h55, acks);
      read_reg(4'd2, q);
      check("reg2_q", q, 9'h0AA);
      read_reg(4'd5, q);
      check("reg5_q", q, 9'h155);
      w0 = wr_pulses;
      write3(8'h34, 8'h1E, 8'h00, acks);
      check("clr_acks", acks, 3'b111);
      check("clr_pulses", wr_pulses - w0, 1);
      check("clr_wr_addr", wr_addr, 7'h0F);
      for (int i = 0; i < 10; i++) begin
         read_reg(i[3:0], q);
         check($sformatf("clr_reg%0d", i), q, 9'd0);
      end

      // Repeated start between byte pairs: first pair dropped, second lands
      w0 = wr_pulses;
      i2c_start();
      send_byte(8'h34, ack);
      send_byte(8'h08, ack);
      write3(8'h34, 8'h0C, 8'h33, acks);
      check("rs_acks", acks, 3'b111);
      check("rs_pulses", wr_pulses - w0, 1);
      read_reg(4'd6, q);
      check("rs_reg6_q", q, 9'h033);

      // Partial byte pair aborted by STOP
      write3(8'h34, 8'h09, 8'h77, acks);
      w0 = wr_pulses;
      i2c_start();
      send_byte(8'h34, ack);
      send_byte(8'h08, ack);
      send_bits(8'hF0, 4);
      i2c_stop();
      check("abort_pulses", wr_pulses - w0, 0);
      check("abort_busy", busy, 1'b0);
      read_reg(4'd4, q);
      check("abort_reg4_q", q, 9'h177);

      // Reset during ADDR_ACK releases SDA within one clock
      i2c_start();
      send_bits(8'h34, 8);
      check("ackrst_oe_before", sda_oe, 1'b1);
      reset = 1'b1;
      tick(1);
      check("ackrst_oe_after", sda_oe, 1'b0);
      check("ackrst_busy", busy, 1'b0);
      tick(3);
      reset = 1'b0;
      tick(Q);
      i2c_stop();
      w0 = wr_pulses;
      write3(8'h34, 8'h0A, 8'h55, acks);
      check("post_rst_acks", acks, 3'b111);
      check("post_rst_pulses", wr_pulses - w0, 1);
      read_reg(4'd5, q);
      check("post_rst_reg5_q", q, 9'h055);
      read_reg(4'd4, q);
      check("post_rst_reg4_q", q, 9'd0);

`ifdef I2C_RESPONDER_READBACK_EN
      // Readback of register 4 = 0x1AB
      write3(8'h34, 8'h09, 8'hAB, acks);
      i2c_start();
      send_byte(8'h35, ack);
      check("rd_addr_ack", ack, 1'b1);
      read_byte(d);
      check("rd_byte_hi", d, 8'h01);
      send_bit(1'b0);
      read_byte(d);
      check("rd_byte_lo", d, 8'hAB);
      send_bit(1'b1);
      check("rd_idle_after_nack", busy, 1'b0);
      check("rd_oe_after_nack", sda_oe, 1'b0);
      i2c_stop();
      check("rd_idle_after_stop", busy, 1'b0);
`else
      // Without readback, R/W=1 is a mismatch
      o0 = oe_clks;
      i2c_start();
      send_byte(8'h35, ack);
      check("rd_off_nack", ack, 1'b0);
      check("rd_off_busy", busy, 1'b1);
      i2c_stop();
      check("rd_off_oe_clks", oe_clks - o0, 0);
      check("rd_off_idle", busy, 1'b0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/i2c_codec_responder.md
I2C_CODEC_RESPONDER -- requirements
Module: i2c_codec_responder

Interface
REQ-001 The block SHALL provide parameter DEV_ADDR, default 7'h1A, meaning the 7-bit I2C target address it responds to.
REQ-002 The block SHALL provide parameter SYNC_STAGES, default 2, meaning the number of synchroniser flops on scl_in and sda_in (minimum 2).
REQ-003 Port clk, input, 1, SHALL be the single system clock; every flop is on its rising edge.
REQ-004 Port reset, input, 1, SHALL be a synchronous, active-high reset.
REQ-005 Port scl_in, input, 1, SHALL be the raw I2C SCL line, asynchronous to clk.
REQ-006 Port sda_in, input, 1, SHALL be the raw I2C SDA line, asynchronous to clk.
REQ-007 Port sda_oe, output, 1, SHALL mean "pull SDA low" when 1; the top level drives the pad to Z when it is 0.
REQ-008 Port wr_valid, output, 1, SHALL be a one-clk pulse that marks an accepted register write.
REQ-009 Port wr_addr, output, 7, SHALL be the register address of the last accepted write.
REQ-010 Port wr_data, output, 9, SHALL be the register data of the last accepted write.
REQ-011 Port reg_sel, input, 4, SHALL select a register-file entry for reg_q.
REQ-012 Port reg_q, output, 9, SHALL return the selected register, registered with 1-clk latency.
REQ-013 Port busy, output, 1, SHALL be 1 from a START until the next STOP or until the transaction is abandoned.

Function
REQ-014 Both SCL and SDA SHALL pass through SYNC_STAGES flops; all edge and condition detection uses the synchronised values.
REQ-015 A START SHALL be detected when SDA falls while SCL is high; a STOP when SDA rises while SCL high.
REQ-016 SDA SHALL be sampled on the synchronised SCL rising edge; sda_oe SHALL change only on the SCL falling edge.
REQ-017 The FSM SHALL have the states IDLE, ADDR, ADDR_ACK, BYTE1, ACK1, BYTE2, ACK2, RD_BYTE, RD_ACK and IGNORE.
REQ-018 In IDLE, a START SHALL move the FSM to ADDR with the bit counter cleared; all other activity is ignored.
REQ-019 In ADDR, the FSM SHALL shift 8 bits MSB first; at the 8th SCL fall it acts on the address match as follows.
- Address equals DEV_ADDR and R/W=0: ADDR_ACK with sda_oe=1.
- Any other case: IGNORE with sda_oe=0.
REQ-020 At the 9th SCL fall, each ACK state SHALL release sda_oe and advance as follows.
- ADDR_ACK goes to BYTE1.
- ACK1 goes to BYTE2.
- ACK2 goes to BYTE1 (auto-increment off; a further byte pair is a new write).
REQ-021 BYTE1 SHALL capture reg_addr[6:0]=bits[7:1] and data[8]=bit[0]; BYTE2 SHALL capture data[7:0]; both bytes are ACKed.
REQ-022 On entry to ACK2 the block SHALL commit the write as follows.
- Register 0..9: update the register-file entry and pulse wr_valid for 1 clk.
- Register 0x0F: clear all entries to 0 and pulse wr_valid.
- Any other register: ACK the byte, discard the data, no wr_valid.
REQ-023 A STOP in any state SHALL return the FSM to IDLE with sda_oe=0; a partial byte pair is discarded with no write.
REQ-024 A START in any non-IDLE state SHALL be a repeated start and go to ADDR.
REQ-025 If a STOP and an SCL edge are flagged on the same clk, the STOP SHALL take priority.
REQ-026 wr_addr and wr_data SHALL hold their values until the next accepted write.

Reset
REQ-027 While reset is high, the block SHALL hold the following values.
- FSM in IDLE; sda_oe, wr_valid and busy at 0.
- wr_addr, wr_data, reg_q and all register entries at 0.
- Synchronisers at 1 (bus idle).
REQ-028 Reset asserted mid-transaction SHALL release SDA within 1 clk; the bus master then sees a NACK or an aborted read.

Configuration
REQ-029 Macro I2C_RESPONDER_READBACK_EN, when defined, SHALL enable reads as follows.
- An address match with R/W=1 is ACKed and goes to RD_BYTE.
- RD_BYTE drives the MSB-first byte {7'b0, reg[8]} then the byte reg[7:0] of the last written register address, bit changes on SCL fall, with RD_ACK between the two bytes.
- A master NACK or a STOP ends the read and returns to IDLE.
REQ-030 Without I2C_RESPONDER_READBACK_EN, R/W=1 SHALL be treated as an address mismatch (NACK, IGNORE), and RD_BYTE and RD_ACK SHALL not be synthesised.

Verification
REQ-031 The bench SHALL cover a write of bytes 0x34, 0x08, 0x12; required response: three ACKs, one wr_valid pulse with wr_addr=4 and wr_data=0x012, and reg_q=0x012 when reg_sel=4.
REQ-032 The bench SHALL cover address byte 0x36; required response: SDA never pulled low, busy falls at STOP, no wr_valid.
REQ-033 The bench SHALL cover writes to registers 2 and 5, then bytes 0x34, 0x1E, 0x00; required response: all registers read 0 and wr_addr=0x0F.
REQ-034 The bench SHALL cover 0x34, 0x08, then 4 bits followed by a STOP; required response: no wr_valid, register 4 unchanged, FSM in IDLE.
REQ-035 The bench SHALL cover reset asserted during ADDR_ACK; required response: sda_oe=0 within 1 clk, and the next write of 0x34, 0x0A, 0x55 succeeds (register 5 = 0x055).
REQ-036 The bench SHALL cover, with I2C_RESPONDER_READBACK_EN defined, a write of register 4 = 0x1AB followed by address byte 0x35; required response: bytes 0x01 and 0xAB returned, and IDLE after the master NACK and STOP.
